// File: rtl/cursor_overlay_pkg.sv
// Shared constants, pixel codes and helpers for the hardware cursor overlay.
package cursor_overlay_pkg;

  localparam int SPRITE_DIM = 16;
  localparam int COORD_W    = 10;

  typedef logic [1:0] pix_t;
  localparam pix_t PIX_TRANSPARENT = 2'd0;
  localparam pix_t PIX_OUTLINE     = 2'd1;
  localparam pix_t PIX_FILL        = 2'd2;

  typedef logic [COORD_W-1:0] coord_t;

  // Stage-1 pipeline payload: sprite address and box hit for one pixel.
  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic       in_box;
  } s1_t;

  // Arrow sprite: outline on col 0 and the diagonal, fill between, blank below row 11.
  function automatic pix_t sprite_pix(input logic [3:0] row, input logic [3:0] col);
    if (row >= 4'd12)               return PIX_TRANSPARENT;
    if (col == 4'd0 || col == row)  return PIX_OUTLINE;
    if (col < row)                  return PIX_FILL;
    return PIX_TRANSPARENT;
  endfunction

  function automatic coord_t clamp_coord(input logic signed [31:0] v, input int lim);
    coord_t r;
    r = v[COORD_W-1:0];
    if (v < 0)        r = '0;
    else if (v >= lim) r = COORD_W'(lim - 1);
    return r;
  endfunction

endpackage

// File: rtl/cursor_overlay_rom.sv
// Registered sprite lookup; forms the second render stage.
import cursor_overlay_pkg::*;

module cursor_rom (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  input  logic       en_i,
  output logic [1:0] pix_o
);

  logic [1:0] pix_q, pix_d;

  always_comb begin
    pix_d = en_i ? sprite_pix(row_i, col_i) : PIX_TRANSPARENT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pix_q <= PIX_TRANSPARENT;
    else          pix_q <= pix_d;
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/cursor_overlay.sv
// Hardware mouse cursor: per-frame position latch, idle auto-hide and a
// two-stage sprite render pipeline keyed off the scan-out coordinates.
import cursor_overlay_pkg::*;

module cursor_overlay #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int HIDE_FRAMES = 180
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic signed [31:0]        mouse_x,
  input  logic signed [31:0]        mouse_y,
  input  logic                      frame_start,
  input  logic                      pix_valid,
  input  logic [COORD_W-1:0]        draw_x,
  input  logic [COORD_W-1:0]        draw_y,
  output logic [COORD_W-1:0]        cur_x,
  output logic [COORD_W-1:0]        cur_y,
  output logic                      cursor_hidden,
  output logic                      out_valid,
  output logic [1:0]                cursor_pix
);

  localparam int STAGES = 2;
  localparam int CNT_W  = ($clog2(HIDE_FRAMES + 1) > 8) ? $clog2(HIDE_FRAMES + 1) : 8;

  coord_t            clamp_x, clamp_y;
  coord_t            cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic              hidden;
  logic [COORD_W:0]  dx, dy;
  s1_t               s1_q, s1_d;
  logic [STAGES:0]   vld_pipe;

  assign clamp_x = clamp_coord(mouse_x, H_RES);
  assign clamp_y = clamp_coord(mouse_y, V_RES);
  assign hidden  = (idle_cnt_q == CNT_W'(HIDE_FRAMES));

  always_comb begin
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    idle_cnt_d = idle_cnt_q;
    if (frame_start) begin
      cur_x_d = clamp_x;
      cur_y_d = clamp_y;
      if (clamp_x == cur_x_q && clamp_y == cur_y_q)
        idle_cnt_d = hidden ? idle_cnt_q : idle_cnt_q + 1'b1;
      else
        idle_cnt_d = '0;
    end
  end

  // Differences are 11-bit signed; negative or >=16 means outside the sprite box,
  // which also clips at the right/bottom edges without wrapping.
  always_comb begin
    dx          = {1'b0, draw_x} - {1'b0, cur_x_q};
    dy          = {1'b0, draw_y} - {1'b0, cur_y_q};
    s1_d.col    = dx[3:0];
    s1_d.row    = dy[3:0];
    s1_d.in_box = pix_valid & ~dx[COORD_W] & (dx[COORD_W-1:4] == '0)
                            & ~dy[COORD_W] & (dy[COORD_W-1:4] == '0);
  end

  assign vld_pipe[0] = pix_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_x_q             <= '0;
      cur_y_q             <= '0;
      idle_cnt_q          <= '0;
      s1_q                <= '0;
      vld_pipe[STAGES:1]  <= '0;
    end else begin
      cur_x_q             <= cur_x_d;
      cur_y_q             <= cur_y_d;
      idle_cnt_q          <= idle_cnt_d;
      s1_q                <= s1_d;
      vld_pipe[STAGES:1]  <= vld_pipe[STAGES-1:0];
    end
  end

  cursor_rom u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .row_i   (s1_q.row),
    .col_i   (s1_q.col),
    .en_i    (s1_q.in_box & ~hidden),
    .pix_o   (cursor_pix)
  );

  assign cur_x         = cur_x_q;
  assign cur_y         = cur_y_q;
  assign cursor_hidden = hidden;
  assign out_valid     = vld_pipe[STAGES];

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed bench for cursor_overlay: clamp, latch, render, auto-hide, edge clip, reset.
module tb_cursor_overlay;

  logic               clk = 1'b0;
  logic               reset_n;
  logic signed [31:0] mouse_x, mouse_y;
  logic               frame_start, pix_valid;
  logic [9:0]         draw_x, draw_y;
  logic [9:0]         cur_x, cur_y;
  logic               cursor_hidden, out_valid;
  logic [1:0]         cursor_pix;

  int n_pass = 0;
  int n_total = 0;

  cursor_overlay dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mouse_x       (mouse_x),
    .mouse_y       (mouse_y),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .draw_x        (draw_x),
    .draw_y        (draw_y),
    .cur_x         (cur_x),
    .cur_y         (cur_y),
    .cursor_hidden (cursor_hidden),
    .out_valid     (out_valid),
    .cursor_pix    (cursor_pix)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame_start pulse with the given mouse position.
  task automatic frame(input int x, input int y);
    mouse_x = x;
    mouse_y = y;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Single valid pixel; returns after the two-cycle render latency.
  task automatic pix(input int x, input int y);
    draw_x = 10'(x);
    draw_y = 10'(y);
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0; mouse_x = 0; mouse_y = 0;
    frame_start = 1'b0; pix_valid = 1'b0; draw_x = '0; draw_y = '0;
    #12;
    check("rst_cur_x", 32'(cur_x), 0);
    check("rst_cur_y", 32'(cur_y), 0);
    check("rst_hidden", 32'(cursor_hidden), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_pix", 32'(cursor_pix), 0);
    reset_n = 1'b1;
    step();

    // Clamp both directions
    frame(-5, 900);
    check("clamp_x", 32'(cur_x), 0);
    check("clamp_y", 32'(cur_y), 479);

    // Basic rendering at (100,50)
    frame(100, 50);
    check("latch_x", 32'(cur_x), 100);
    check("latch_y", 32'(cur_y), 50);
    pix(100, 50);
    check("r0c0_valid", 32'(out_valid), 1);
    check("r0c0_pix", 32'(cursor_pix), 1);
    check("valid_drops", 32'(out_valid), 1);
    step();
    check("valid_low", 32'(out_valid), 0);
    pix(101, 52); check("r2c1_fill", 32'(cursor_pix), 2);
    pix(105, 52); check("r2c5_clear", 32'(cursor_pix), 0);
    pix(99, 50);  check("left_of_box", 32'(cursor_pix), 0);

    // Auto-hide: 179 unchanged frames not yet hidden, 180th hides
    for (int i = 0; i < 179; i++) frame(100, 50);
    check("hide_179", 32'(cursor_hidden), 0);
    frame(100, 50);
    check("hide_180", 32'(cursor_hidden), 1);
    frame(100, 50);
    check("hide_sat", 32'(cursor_hidden), 1);
    pix(100, 50); check("hidden_pix", 32'(cursor_pix), 0);
    frame(101, 50);
    check("unhide", 32'(cursor_hidden), 0);
    check("idle_cnt_clr", 32'(dut.idle_cnt_q), 0);
    pix(101, 50); check("unhide_pix", 32'(cursor_pix), 1);

    // Bottom-right clipping, no wrap
    frame(635, 475);
    pix(639, 479); check("edge_r4c4", 32'(cursor_pix), 1);
    pix(0, 479);   check("no_wrap", 32'(cursor_pix), 0);

    // frame_start coincident with pix_valid uses old position
    frame(10, 10);
    mouse_x = 300; mouse_y = 300; frame_start = 1'b1;
    draw_x = 10; draw_y = 10; pix_valid = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    check("coincident_old", 32'(cursor_pix), 1);
    pix_valid = 1'b0;
    step();
    check("next_new_pos", 32'(cursor_pix), 0);
    check("new_cur_x", 32'(cur_x), 300);

    // Asynchronous reset mid-stream
    draw_x = 301; draw_y = 302; pix_valid = 1'b1;
    step(); step();
    check("pre_rst_fill", 32'(cursor_pix), 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_pix", 32'(cursor_pix), 0);
    check("arst_valid", 32'(out_valid), 0);
    check("arst_cur_x", 32'(cur_x), 0);
    check("arst_cur_y", 32'(cur_y), 0);
    pix_valid = 1'b0;
    #3;
    reset_n = 1'b1;
    step();
    pix(0, 0); check("post_rst_origin", 32'(cursor_pix), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cursor_overlay.md
CURSOR_OVERLAY -- requirements
Module: cursor_overlay

Interface
REQ-001 Parameter H_RES, default 640, horizontal active pixels.
REQ-002 Parameter V_RES, default 480, vertical active lines.
REQ-003 Parameter HIDE_FRAMES, default 180, count of unchanged frames before the cursor auto-hides.
REQ-004 clk  input  1  pixel/system clock.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 mouse_x  input  32  signed X position from the software-written PIO out_port.
REQ-007 mouse_y  input  32  signed Y position from the software-written PIO out_port.
REQ-008 frame_start  input  1  single-cycle pulse at start of vertical blank.
REQ-009 pix_valid  input  1  draw_x/draw_y are valid this cycle.
REQ-010 draw_x  input  10  current pixel column.
REQ-011 draw_y  input  10  current pixel row.
REQ-012 cur_x  output  10  latched clamped cursor X.
REQ-013 cur_y  output  10  latched clamped cursor Y.
REQ-014 cursor_hidden  output  1  auto-hide active.
REQ-015 out_valid  output  1  cursor_pix is valid.
REQ-016 cursor_pix  output  2  0 transparent, 1 outline, 2 fill.

Function
REQ-017 Clamp: mouse_x is treated as signed; <0 -> 0, >=H_RES -> H_RES-1, else low 10 bits; mouse_y likewise against V_RES.
REQ-018 Position latch: on frame_start, cur_x/cur_y load the clamped values, visible the following cycle; cur_x/cur_y are held between pulses.
REQ-019 Idle counter (8+ bits): on frame_start, clamped position equal to held cur_x/cur_y -> increment, saturating at HIDE_FRAMES; otherwise clear to 0.
REQ-020 cursor_hidden is 1 exactly when the idle counter equals HIDE_FRAMES; the first frame_start with a changed position clears it the next cycle.
REQ-021 Render pipeline, stage 1: register dx = draw_x - cur_x and dy = draw_y - cur_y (11-bit signed), plus in_box = (0<=dx<16) and (0<=dy<16) and pix_valid.
REQ-022 Render pipeline, stage 2: sprite lookup at (row=dy[3:0], col=dx[3:0]); cursor_pix is the sprite value if in_box and not hidden, else 0.
REQ-023 out_valid is pix_valid delayed exactly 2 cycles; latency from draw_x/draw_y to cursor_pix is 2 cycles.
REQ-024 Sprite: for rows 0..11, col 0 or col==row -> 1; 0<col<row -> 2; else 0; rows 12..15 are all 0.
REQ-025 A sprite crossing the right or bottom edge is clipped implicitly; no wrap to column or row 0.
REQ-026 frame_start coincident with pix_valid: that pixel renders with the old cur_x/cur_y.
REQ-027 pix_valid low: in_box is forced 0 and cursor_pix is 0 when out_valid is low.

Reset
REQ-028 While reset_n is low, all outputs are 0, the idle counter is 0, and the pipeline registers are cleared.
REQ-029 Reset asserted mid-frame takes effect immediately (asynchronous); rendering after release uses position (0,0) until the next frame_start.

Structure
REQ-030 A shared package holds SPRITE_DIM=16, the pixel-code constants (TRANSPARENT=0, OUTLINE=1, FILL=2) and the coordinate width (10).
REQ-031 Sub-module cursor_rom: 4-bit row and col in, registered 2-bit pixel out; it forms pipeline stage 2.
REQ-032 All state is clocked on the rising edge of clk; there are no other clock domains.

Verification
REQ-033 mouse_x=-5, mouse_y=900, frame_start pulse -> cur_x=0, cur_y=479 one cycle later.
REQ-034 cur=(100,50); draw (100,50) with pix_valid -> after 2 cycles out_valid=1, cursor_pix=1; draw (101,52) -> 2; draw (105,52) -> 0; draw (99,50) -> 0.
REQ-035 Position constant for 180 frame_start pulses -> cursor_hidden=1 and the pixel at (cur_x,cur_y) reads 0; change mouse_x by 1 with a further pulse -> hidden=0 and the counter is 0.
REQ-036 cur=(635,475); draw (639,479) -> cursor_pix=1 (row4,col4); draw (0,479) -> 0, confirming no wrap.
REQ-037 frame_start and pix_valid in the same cycle, with the old position (10,10), new position (300,300) and draw (10,10) -> cursor_pix=1; the same draw one cycle later -> 0.
REQ-038 Assert reset_n low mid-stream with cursor_pix=2 -> all outputs 0 immediately; release and draw (0,0) -> cursor_pix=1.
